// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: single-cycle integer ops plus an optional
// iterative shift-add multiplier enabled by defining ALU_EXEC_MUL_EN.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       alu_op_i,
  input  logic [4:0]       funct_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg, zero_next;
  logic             illegal_reg, illegal_next;

  logic [WIDTH-1:0] alu_res;
  logic             alu_illegal;
  logic [SHW-1:0]   shamt;

  assign shamt = src2_i[SHW-1:0];

`ifdef ALU_EXEC_MUL_EN
  logic             alu_mul;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [SHW-1:0]   count_reg, count_next;
  logic [WIDTH-1:0] step_sum;

  assign step_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`endif

  // Operation decode straight from the request inputs; only used at acceptance.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
`ifdef ALU_EXEC_MUL_EN
    alu_mul     = 1'b0;
`endif
    case (alu_op_i)
      2'b00: alu_res = src1_i + src2_i;
      2'b01: alu_res = src1_i - src2_i;
      2'b10: begin
        if (!funct_i[4]) begin
          case (funct_i[3:0])
            4'b0000: alu_res = src1_i + src2_i;
            4'b1000: alu_res = src1_i - src2_i;
            4'b0111: alu_res = src1_i & src2_i;
            4'b0110: alu_res = src1_i | src2_i;
            4'b0100: alu_res = src1_i ^ src2_i;
            4'b0010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            4'b0001: alu_res = src1_i << shamt;
            4'b1101: alu_res = $signed(src1_i) >>> shamt;
            default: alu_illegal = 1'b1;
          endcase
        end else begin
`ifdef ALU_EXEC_MUL_EN
          if (funct_i[3:0] == 4'b0000) alu_mul = 1'b1;
          else                          alu_illegal = 1'b1;
`else
          alu_illegal = 1'b1;
`endif
        end
      end
      default: alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    result_next  = result_reg;
    zero_next    = zero_reg;
    illegal_next = illegal_reg;
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
`ifdef ALU_EXEC_MUL_EN
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    acc_next     = acc_reg;
    count_next   = count_reg;
`endif
    case (state_reg)
      IDLE: in_ready_o = 1'b1;
`ifdef ALU_EXEC_MUL_EN
      BUSY: begin
        acc_next    = step_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        count_next  = count_reg + 1'b1;
        if (count_reg == SHW'(WIDTH-1)) begin
          state_next   = DONE;
          result_next  = step_sum;
          zero_next    = (step_sum == '0);
          illegal_next = 1'b0;
        end
      end
`endif
      DONE: begin
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i;
        if (out_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A new acceptance overrides the drain-to-IDLE decision above (no bubble).
    if (in_valid_i && in_ready_o) begin
`ifdef ALU_EXEC_MUL_EN
      if (alu_mul) begin
        state_next  = BUSY;
        mcand_next  = src1_i;
        mplier_next = src2_i;
        acc_next    = '0;
        count_next  = '0;
      end else begin
        state_next   = DONE;
        result_next  = alu_illegal ? '0 : alu_res;
        zero_next    = alu_illegal || (alu_res == '0);
        illegal_next = alu_illegal;
      end
`else
      state_next   = DONE;
      result_next  = alu_illegal ? '0 : alu_res;
      zero_next    = alu_illegal || (alu_res == '0);
      illegal_next = alu_illegal;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg   <= IDLE;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      result_reg  <= result_next;
      zero_reg    <= zero_next;
      illegal_reg <= illegal_next;
    end
  end

`ifdef ALU_EXEC_MUL_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
    end else begin
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      count_reg  <= count_next;
    end
  end
`endif

  assign result_o  = result_reg;
  assign zero_o    = zero_reg;
  assign illegal_o = illegal_reg;

endmodule
